mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 22 ++
 rtl/mem_arbiter_arb_pick.sv | 24 ++
 rtl/mem_arbiter.sv | 116 +++++++++++
 tb/tb_mem_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the icache/dcache memory arbiter.
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int LINE_W_DEF = 512;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  function automatic owner_e to_owner(input logic is_d);
    return is_d ? OWN_D : OWN_I;
  endfunction

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Tie-break between icache and dcache requests.
// MEM_ARB_RR_EN: alternate on ties using the last grant; otherwise dcache wins ties.
module arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  owner_e last,
  output logic   grant_d
);

`ifdef MEM_ARB_RR_EN
  always_comb begin
    grant_d = d_req;
    if (i_req && d_req) grant_d = (last == OWN_I);
  end
`else
  // Fixed priority never consults the icache request or the grant history.
  logic unused_in;
  assign unused_in = ^{i_req, last};
  assign grant_d   = d_req;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (icache/dcache) line arbiter in front of a single memory port.
// Optional macro MEM_ARB_RR_EN enables round-robin tie-break with a last-grant register.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [LINE_W-1:0] d_rdata,
  output logic              mem_addr_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write_data_valid,
  output logic [LINE_W-1:0] mem_write_data,
  input  logic              mem_read_data_ready,
  input  logic [LINE_W-1:0] mem_read_data
);

  state_e            state_q;
  owner_e            owner_q;
  owner_e            last_sel;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [LINE_W-1:0] i_rdata_q, d_rdata_q;
  logic              mav_q, mwv_q, we_d;
  logic              i_ack_q, d_ack_q;
  logic              grant_d;

`ifdef MEM_ARB_RR_EN
  owner_e last_q;
  assign last_sel = last_q;
`else
  assign last_sel = OWN_I;
`endif

  arb_pick u_pick (
    .i_req   (i_req),
    .d_req   (d_req),
    .last    (last_sel),
    .grant_d (grant_d)
  );

  // Capture values for the winner; write data is zeroed unless it is a writeback.
  assign addr_d  = grant_d ? d_addr : i_addr;
  assign we_d    = grant_d & d_we;
  assign wdata_d = we_d ? d_wdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= OWN_I;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      mav_q     <= 1'b0;
      mwv_q     <= 1'b0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_q    <= OWN_I;
`endif
    end else begin
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_req || d_req) begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            owner_q <= to_owner(grant_d);
            mav_q   <= 1'b1;
            mwv_q   <= we_d;
            state_q <= BUSY;
`ifdef MEM_ARB_RR_EN
            last_q  <= to_owner(grant_d);
`endif
          end
        end
        BUSY: begin
          if (mem_read_data_ready) begin
            if (owner_q == OWN_D) d_rdata_q <= mem_read_data;
            else                  i_rdata_q <= mem_read_data;
            i_ack_q <= (owner_q == OWN_I);
            d_ack_q <= (owner_q == OWN_D);
            mav_q   <= 1'b0;
            mwv_q   <= 1'b0;
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_addr_valid       = mav_q;
  assign mem_addr             = mav_q ? addr_q : '0;
  assign mem_write_data_valid = mwv_q;
  assign mem_write_data       = mwv_q ? wdata_q : '0;
  assign i_ack                = i_ack_q;
  assign d_ack                = d_ack_q;
  assign i_rdata              = i_rdata_q;
  assign d_rdata              = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed table, corner sequences, randomized rounds.
module tb_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 512;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam logic [LINE_W-1:0] PAT_A = {(LINE_W/32){32'hA5A5_1234}};
  localparam logic [LINE_W-1:0] PAT_B = {(LINE_W/32){32'h5A5A_BEEF}};
  localparam logic [LINE_W-1:0] PAT_C = {(LINE_W/32){32'h0F1E_2D3C}};

  logic              clk, rst_n;
  logic              i_req, d_req, d_we;
  logic [ADDR_W-1:0] i_addr, d_addr;
  logic [LINE_W-1:0] d_wdata, mem_read_data;
  logic              mem_read_data_ready;
  logic              i_ack, d_ack, mem_addr_valid, mem_write_data_valid;
  logic [LINE_W-1:0] i_rdata, d_rdata, mem_write_data;
  logic [ADDR_W-1:0] mem_addr;

  mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_addr_valid(mem_addr_valid), .mem_addr(mem_addr),
    .mem_write_data_valid(mem_write_data_valid), .mem_write_data(mem_write_data),
    .mem_read_data_ready(mem_read_data_ready), .mem_read_data(mem_read_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int vecs = 0;
  int errs = 0;

  typedef struct {
    bit                ireq, dreq, dwe;
    logic [ADDR_W-1:0] iaddr, daddr;
    logic [LINE_W-1:0] wdata, rdata;
    int                busy;
    bit                exp_d;
    logic [ADDR_W-1:0] exp_addr;
    bit                exp_wv;
    int                exp_lat;
  } vec_t;

  vec_t tbl[5];

  function automatic vec_t mk(bit ir, bit dr, bit we, logic [ADDR_W-1:0] ia, logic [ADDR_W-1:0] da,
                              logic [LINE_W-1:0] wd, logic [LINE_W-1:0] rd, int busy, bit ed,
                              logic [ADDR_W-1:0] ea, bit ewv, int lat);
    vec_t v;
    v.ireq = ir; v.dreq = dr; v.dwe = we; v.iaddr = ia; v.daddr = da;
    v.wdata = wd; v.rdata = rd; v.busy = busy; v.exp_d = ed;
    v.exp_addr = ea; v.exp_wv = ewv; v.exp_lat = lat;
    return v;
  endfunction

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    v = '0;
    for (int k = 0; k < LINE_W/32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_req = 1'b0; d_req = 1'b0;
    mem_read_data_ready = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  // Called with requests already driven and the arbiter idle; returns one cycle after the ack.
  task automatic serve(input string tag, input bit exp_d, input logic [ADDR_W-1:0] exp_addr,
                       input bit exp_wv, input logic [LINE_W-1:0] exp_wdata, input int busy,
                       input logic [LINE_W-1:0] rdata, input int exp_lat, input bit mid);
    int lat, n;
    lat = 1; n = 0;
    while (!mem_addr_valid && n < 8) begin step(); lat++; n++; end
    chk({tag, " mem_addr_valid"}, mem_addr_valid, 1);
    chk({tag, " mem_addr"}, mem_addr, exp_addr);
    chk({tag, " write_valid"}, mem_write_data_valid, exp_wv);
    chk({tag, " write_data"}, mem_write_data, exp_wdata);
    for (int k = 1; k < busy; k++) begin
      if (mid && k == 1) begin
        i_addr = ~i_addr;
        d_req  = 1'b1;
      end
      step(); lat++;
      chk({tag, " addr_hold"}, mem_addr, exp_addr);
      chk({tag, " ack_in_busy"}, {i_ack, d_ack}, 0);
    end
    mem_read_data = rdata;
    mem_read_data_ready = 1'b1;
    step(); lat++;
    mem_read_data_ready = 1'b0;
    mem_read_data = rand_line();
    n = 0;
    while (!(i_ack || d_ack) && n < 8) begin step(); lat++; n++; end
    chk({tag, " i_ack"}, i_ack, !exp_d);
    chk({tag, " d_ack"}, d_ack, exp_d);
    chk({tag, " rdata"}, exp_d ? d_rdata : i_rdata, rdata);
    chk({tag, " valid_in_done"}, mem_addr_valid, 0);
    chk({tag, " latency"}, lat, exp_lat);
    step();
    chk({tag, " ack_pulse"}, {i_ack, d_ack}, 0);
    chk({tag, " rdata_hold"}, exp_d ? d_rdata : i_rdata, rdata);
  endtask

  initial begin
    bit pi, pd, wd, last_m;
    int busy;
    logic [LINE_W-1:0] rd;

    rst_n = 1'b0;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    mem_read_data_ready = 1'b0; mem_read_data = '0;
    step(); step();
    chk("reset mem_addr_valid", mem_addr_valid, 0);
    chk("reset write_valid", mem_write_data_valid, 0);
    chk("reset acks", {i_ack, d_ack}, 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset mem_write_data", mem_write_data, 0);
    chk("reset i_rdata", i_rdata, 0);
    chk("reset d_rdata", d_rdata, 0);
    rst_n = 1'b1;
    step();

    tbl[0] = mk(1, 0, 0, 32'h0000_1040, 32'h0, '0, PAT_A, 2, 0, 32'h0000_1040, 0, 4);
    tbl[1] = mk(0, 1, 1, 32'h0, 32'h0000_2000, PAT_B, PAT_C, 1, 1, 32'h0000_2000, 1, 3);
    tbl[2] = mk(0, 1, 0, 32'h0, 32'h0000_3000, PAT_B, PAT_C, 3, 1, 32'h0000_3000, 0, 5);
    tbl[3] = mk(1, 1, 0, 32'h0000_4000, 32'h0000_5000, PAT_A, PAT_A, 1, !RR,
                RR ? 32'h0000_4000 : 32'h0000_5000, 0, 3);
    tbl[4] = mk(1, 1, 1, 32'h0000_4400, 32'h0000_5400, PAT_C, PAT_B, 2, 1, 32'h0000_5400, 1, 4);

    for (int r = 0; r < 5; r++) begin
      i_req = tbl[r].ireq; i_addr = tbl[r].iaddr;
      d_req = tbl[r].dreq; d_we = tbl[r].dwe; d_addr = tbl[r].daddr; d_wdata = tbl[r].wdata;
      serve($sformatf("vec%0d", r), tbl[r].exp_d, tbl[r].exp_addr, tbl[r].exp_wv,
            tbl[r].exp_wv ? tbl[r].wdata : '0, tbl[r].busy, tbl[r].rdata, tbl[r].exp_lat, 1'b0);
      i_req = 1'b0; d_req = 1'b0;
      step();
    end

    // Simultaneous requests twice from reset: the loser keeps requesting and follows.
    do_reset();
    for (int rep = 0; rep < 2; rep++) begin
      i_addr = 32'h0000_A000 + rep; d_addr = 32'h0000_B000 + rep; d_we = 1'b0;
      i_req = 1'b1; d_req = 1'b1;
      serve($sformatf("tie%0d first", rep), 1, d_addr, 0, '0, 1, rand_line(), 3, 1'b0);
      d_req = 1'b0;
      serve($sformatf("tie%0d second", rep), 0, i_addr, 0, '0, 1, rand_line(), 3, 1'b0);
      i_req = 1'b0;
      step();
    end

    // Icache owns; dcache arrives and icache address moves mid-transaction.
    i_addr = 32'h0000_6000; i_req = 1'b1;
    d_addr = 32'h0000_7000; d_we = 1'b0; d_req = 1'b0;
    serve("mid I", 0, 32'h0000_6000, 0, '0, 3, rand_line(), 5, 1'b1);
    i_req = 1'b0;
    serve("mid D", 1, 32'h0000_7000, 0, '0, 1, rand_line(), 3, 1'b0);
    d_req = 1'b0;
    step();

    // Reset during BUSY abandons the transaction.
    i_addr = 32'h0000_8000; i_req = 1'b1;
    step();
    chk("rstbusy in_busy", mem_addr_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstbusy async_valid", mem_addr_valid, 0);
    i_req = 1'b0;
    mem_read_data = PAT_C; mem_read_data_ready = 1'b1;
    step();
    chk("rstbusy no_ack", {i_ack, d_ack}, 0);
    mem_read_data_ready = 1'b0;
    step();
    rst_n = 1'b1;
    step(); step();
    chk("rstbusy idle_valid", mem_addr_valid, 0);
    chk("rstbusy idle_ack", {i_ack, d_ack}, 0);
    i_addr = 32'h0000_9000; i_req = 1'b1;
    serve("after rst", 0, 32'h0000_9000, 0, '0, 1, PAT_B, 3, 1'b0);
    i_req = 1'b0;
    last_m = 1'b0;

    // Randomized rounds against a pending-set model.
    for (int r = 0; r < 30; r++) begin
      pi = 1'($urandom_range(0, 1));
      pd = 1'($urandom_range(0, 1));
      if (!pi && !pd) pd = 1'b1;
      i_addr = $urandom; d_addr = $urandom; d_we = 1'($urandom_range(0, 1)); d_wdata = rand_line();
      i_req = pi; d_req = pd;
      while (pi || pd) begin
        if (pi && pd) wd = RR ? (last_m == 1'b0) : 1'b1;
        else          wd = pd;
        busy = $urandom_range(1, 4);
        rd = rand_line();
        serve($sformatf("rnd%0d %s", r, wd ? "D" : "I"), wd, wd ? d_addr : i_addr, wd && d_we,
              (wd && d_we) ? d_wdata : '0, busy, rd, busy + 2, 1'b0);
        last_m = wd;
        if (wd) begin pd = 1'b0; d_req = 1'b0; end
        else    begin pi = 1'b0; i_req = 1'b0; end
      end
      repeat ($urandom_range(1, 3)) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
